// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: a single-outstanding fetcher that fills a circular buffer
// and presents the two oldest instructions, with their pcs, to the scheduler.
module inst_fetch_queue #(
    parameter int unsigned     DEPTH    = 16,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       freeze,
    input  logic [1:0]                 consume_cnt,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       mem_req,
    output logic [XLEN-1:0]            mem_addr,
    input  logic [XLEN-1:0]            mem_rdata,
    input  logic                       mem_valid,
    output logic [XLEN-1:0]            ins0,
    output logic [XLEN-1:0]            ins1,
    output logic [XLEN-1:0]            ins0_pc,
    output logic [XLEN-1:0]            ins1_pc,
    output logic                       ins0_valid,
    output logic                       ins1_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] head_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;

    logic [1:0]       want;
    logic [1:0]       pops;
    logic             push;

    // A request, once raised, is held until its response; a new one needs a free slot.
    // Gating with rst_n keeps the request low while reset is held.
    assign mem_req  = rst_n && !discard_q && (outstanding_q || (count_q < CNT_W'(DEPTH)));
    assign mem_addr = fetch_pc_q;
    assign push     = mem_req && mem_valid && !redirect;

    always_comb begin
        want = (consume_cnt == 2'd3) ? 2'd2 : consume_cnt;
        pops = want;
        if (freeze || redirect) begin
            pops = 2'd0;
        end else if (CNT_W'(want) > count_q) begin
            pops = count_q[1:0];
        end
    end

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            fetch_pc_d    = redirect_pc;
            outstanding_d = 1'b0;
            // Any request still in flight will answer later and must be thrown away.
            discard_d     = !mem_valid && (discard_q || mem_req);
        end else begin
            head_d        = head_q + PTR_W'(pops);
            tail_d        = tail_q + PTR_W'(push);
            count_d       = count_q + CNT_W'(push) - CNT_W'(pops);
            if (push) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outstanding_d = mem_req && !mem_valid;
            discard_d     = discard_q && !mem_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[tail_q] <= mem_rdata;
            pc_q[tail_q]    <= fetch_pc_q;
        end
    end

    assign head_p1    = head_q + PTR_W'(1);
    assign ins0_valid = (count_q != '0);
    assign ins1_valid = (count_q >= CNT_W'(2));
    // Unoccupied slots read as zero so stale storage never leaks out.
    assign ins0       = ins0_valid ? instr_q[head_q]  : '0;
    assign ins0_pc    = ins0_valid ? pc_q[head_q]     : '0;
    assign ins1       = ins1_valid ? instr_q[head_p1] : '0;
    assign ins1_pc    = ins1_valid ? pc_q[head_p1]    : '0;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));

endmodule
